// File: rtl/cordic_pkg.sv
// Shared types and helpers for the CORDIC pre-processing pipeline.
// Payload fields are sized for the widest legal sample; narrower instances keep the upper bits zero.
package cordic_pkg;

    localparam int unsigned MAX_DATA_W = 32;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_t;

    typedef struct packed {
        logic [MAX_DATA_W-1:0] re;
        logic [MAX_DATA_W-1:0] im;
        quadrant_t             quadrant;
        logic                  exchanged;
    } pre_sample_t;

    // Magnitude of a sign-extended w-bit value; the most negative code clips to the largest positive one.
    function automatic logic [MAX_DATA_W-1:0] sat_abs(input logic [MAX_DATA_W-1:0] x,
                                                      input int unsigned          w);
        logic signed [MAX_DATA_W:0] v;
        logic signed [MAX_DATA_W:0] lim;
        v   = {x[MAX_DATA_W-1], x};
        lim = (MAX_DATA_W+1)'(1) << (w - 1);
        if (v <= -lim) begin
            return MAX_DATA_W'(lim - (MAX_DATA_W+1)'(1));
        end else if (v[MAX_DATA_W]) begin
            return MAX_DATA_W'(-v);
        end else begin
            return MAX_DATA_W'(v);
        end
    endfunction

    // Quadrant id from the sign bits; zero counts as non-negative.
    function automatic quadrant_t quad_of(input logic neg_re, input logic neg_im);
        return quadrant_t'({neg_im, neg_re ^ neg_im});
    endfunction

endpackage

// File: rtl/cordic_pre_slice.sv
// One valid/ready register slice carrying a pre_sample_t.
// Accepts a new word when empty or when the current word leaves in the same cycle.
module cordic_pre_slice
    import cordic_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        up_valid,
    input  pre_sample_t up_data,
    output logic        up_ready_c,
    output logic        dn_valid,
    output pre_sample_t dn_data,
    input  logic        dn_ready
);

    logic        valid_q;
    logic        valid_d;
    pre_sample_t data_q;
    pre_sample_t data_d;

    always_comb begin
        up_ready_c = !valid_q || dn_ready;
        valid_d    = valid_q;
        data_d     = data_q;
        if (up_ready_c) begin
            valid_d = up_valid;
            if (up_valid) begin
                data_d = up_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign dn_valid = valid_q;
    assign dn_data  = data_q;

endmodule

// File: rtl/cordic_pre_pipe.sv
// Folds a signed complex sample into the first octant ahead of the CORDIC core.
// Stage 1 takes magnitudes and quadrant, stage 2 orders the components, later stages only delay.
module cordic_pre_pipe
    import cordic_pkg::*;
#(
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned N_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic [1:0]        out_quadrant,
    output logic              out_exchanged,
    output logic              out_valid,
    input  logic              out_ready
);

    if (DATA_W < 4 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
        $error("cordic_pre_pipe: DATA_W must be in 4..32");
    end
    if (N_STAGES < 1 || N_STAGES > 4) begin : g_bad_n_stages
        $error("cordic_pre_pipe: N_STAGES must be in 1..4");
    end

    // Put the larger magnitude on re; ties keep the original order.
    function automatic pre_sample_t fold_swap(input pre_sample_t s);
        pre_sample_t r;
        r = s;
        if (s.im > s.re) begin
            r.re        = s.im;
            r.im        = s.re;
            r.exchanged = 1'b1;
        end
        return r;
    endfunction

    logic [MAX_DATA_W-1:0] re_sx;
    logic [MAX_DATA_W-1:0] im_sx;
    pre_sample_t           front_c;

    always_comb begin
        re_sx              = MAX_DATA_W'($signed(in_re));
        im_sx              = MAX_DATA_W'($signed(in_im));
        front_c            = '0;
        front_c.re         = sat_abs(re_sx, DATA_W);
        front_c.im         = sat_abs(im_sx, DATA_W);
        front_c.quadrant   = quad_of(in_re[DATA_W-1], in_im[DATA_W-1]);
        front_c.exchanged  = 1'b0;
    end

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stg
        logic        up_valid;
        logic        up_ready_c;
        pre_sample_t up_data;
        logic        dn_valid;
        logic        dn_ready;
        pre_sample_t dn_data;

        if (k == 0) begin : g_head
            assign up_valid = in_valid;
            assign in_ready = up_ready_c;
            assign up_data  = (N_STAGES == 1) ? fold_swap(front_c) : front_c;
        end else begin : g_body
            assign up_valid = g_stg[k-1].dn_valid;
            assign up_data  = (k == 1) ? fold_swap(g_stg[k-1].dn_data) : g_stg[k-1].dn_data;
        end

        // Ready ripples combinationally from the output back to the input.
        if (k == N_STAGES - 1) begin : g_tail
            assign dn_ready      = out_ready;
            assign out_valid     = dn_valid;
            assign out_re        = DATA_W'(dn_data.re);
            assign out_im        = DATA_W'(dn_data.im);
            assign out_quadrant  = dn_data.quadrant;
            assign out_exchanged = dn_data.exchanged;
        end else begin : g_link
            assign dn_ready = g_stg[k+1].up_ready_c;
        end

        cordic_pre_slice u_slice (
            .clk        (clk),
            .rst        (rst),
            .up_valid   (up_valid),
            .up_data    (up_data),
            .up_ready_c (up_ready_c),
            .dn_valid   (dn_valid),
            .dn_data    (dn_data),
            .dn_ready   (dn_ready)
        );
    end

endmodule

// File: tb/tb_cordic_pre_pipe.sv
// Scoreboard bench for cordic_pre_pipe: a depth-2 main instance plus depth-1 and depth-4 instances on shared inputs.
module tb_cordic_pre_pipe;

    localparam int unsigned W = 12;

    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic [1:0]   q;
        logic         x;
    } res_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] in_re;
    logic [W-1:0] in_im;
    logic         in_valid;
    logic         out_ready;

    logic         in_ready, out_valid, out_exchanged;
    logic [W-1:0] out_re, out_im;
    logic [1:0]   out_quadrant;
    logic         a_in_ready, a_out_valid, a_out_exchanged;
    logic [W-1:0] a_out_re, a_out_im;
    logic [1:0]   a_out_quadrant;
    logic         b_in_ready, b_out_valid, b_out_exchanged;
    logic [W-1:0] b_out_re, b_out_im;
    logic [1:0]   b_out_quadrant;

    int   n_vec;
    int   n_err;
    res_t exp_q[$];

    cordic_pre_pipe #(.DATA_W(W), .N_STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_re(in_re), .in_im(in_im), .in_valid(in_valid),
        .in_ready(in_ready), .out_re(out_re), .out_im(out_im), .out_quadrant(out_quadrant),
        .out_exchanged(out_exchanged), .out_valid(out_valid), .out_ready(out_ready)
    );

    cordic_pre_pipe #(.DATA_W(W), .N_STAGES(1)) dut_n1 (
        .clk(clk), .rst(rst), .in_re(in_re), .in_im(in_im), .in_valid(in_valid),
        .in_ready(a_in_ready), .out_re(a_out_re), .out_im(a_out_im), .out_quadrant(a_out_quadrant),
        .out_exchanged(a_out_exchanged), .out_valid(a_out_valid), .out_ready(out_ready)
    );

    cordic_pre_pipe #(.DATA_W(W), .N_STAGES(4)) dut_n4 (
        .clk(clk), .rst(rst), .in_re(in_re), .in_im(in_im), .in_valid(in_valid),
        .in_ready(b_in_ready), .out_re(b_out_re), .out_im(b_out_im), .out_quadrant(b_out_quadrant),
        .out_exchanged(b_out_exchanged), .out_valid(b_out_valid), .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: fold a sample straight from the quadrant table and magnitude rules.
    function automatic res_t model(input logic [W-1:0] re, input logic [W-1:0] im);
        int   r, i, ar, ai, mx;
        res_t m;
        mx = (1 << (W - 1)) - 1;
        r  = int'($signed(re));
        i  = int'($signed(im));
        ar = (r < 0) ? -r : r;
        ai = (i < 0) ? -i : i;
        if (ar > mx) ar = mx;
        if (ai > mx) ai = mx;
        if (r >= 0 && i >= 0)     m.q = 2'd0;
        else if (r < 0 && i >= 0) m.q = 2'd1;
        else if (r < 0)           m.q = 2'd2;
        else                      m.q = 2'd3;
        if (ai > ar) begin
            m.re = W'(ai); m.im = W'(ar); m.x = 1'b1;
        end else begin
            m.re = W'(ar); m.im = W'(ai); m.x = 1'b0;
        end
        return m;
    endfunction

    // One clock of the main instance: record input handshake, pop expectation on output handshake.
    task automatic sample(output bit acc, output bit got, output logic ov,
                          output res_t e, output res_t o);
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(model(in_re, in_im));
        ov  = out_valid;
        o   = {out_re, out_im, out_quadrant, out_exchanged};
        got = out_valid && out_ready;
        e   = 'x;
        if (got && exp_q.size() > 0) e = exp_q.pop_front();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_re = '0; in_im = '0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({out_re, out_im, out_quadrant, out_exchanged, out_valid} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got re=%h im=%h q=%h x=%b v=%b want all 0",
                     out_re, out_im, out_quadrant, out_exchanged, out_valid);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed(input logic [W-1:0] re, input logic [W-1:0] im,
                                 input res_t want, input string name);
        bit   acc, got, done;
        logic ov;
        res_t e, o;
        int   lat;
        in_re = re; in_im = im; in_valid = 1'b1; out_ready = 1'b1;
        sample(acc, got, ov, e, o);
        in_valid = 1'b0;
        n_vec++;
        if (!acc) begin
            n_err++; $display("FAIL %s_accept: in_ready got 0 want 1", name);
        end
        lat = 0; done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            sample(acc, got, ov, e, o);
            lat++;
            if (got) begin
                done = 1;
                n_vec++;
                if (o !== want) begin
                    n_err++; $display("FAIL %s_value: got %h want %h", name, o, want);
                end
                n_vec++;
                if (o !== e) begin
                    n_err++; $display("FAIL %s_sb: got %h want %h", name, o, e);
                end
                n_vec++;
                if (lat != 2) begin
                    n_err++; $display("FAIL %s_latency: got %0d want 2", name, lat);
                end
            end
        end
        if (!done) begin
            n_vec++; n_err++; $display("FAIL %s_timeout: got no output want one", name);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] sr[16];
        logic [W-1:0] si[16];
        bit   acc, got, was_valid;
        logic ov;
        res_t e, o;
        int   idx, outs, first, last;
        sr[0] = 12'h800; si[0] = 12'h7FF;
        sr[1] = 12'h000; si[1] = 12'h800;
        sr[2] = 12'hFFF; si[2] = 12'h001;
        sr[3] = 12'h123; si[3] = 12'hEDD;
        for (int k = 4; k < 16; k++) begin
            sr[k] = W'($urandom); si[k] = W'($urandom);
        end
        idx = 0; outs = 0; first = -1; last = -1; out_ready = 1'b1;
        for (int c = 0; c < 40 && outs < 16; c++) begin
            in_valid = (idx < 16);
            if (idx < 16) begin in_re = sr[idx]; in_im = si[idx]; end
            was_valid = in_valid;
            sample(acc, got, ov, e, o);
            if (was_valid) begin
                n_vec++;
                if (!acc) begin
                    n_err++; $display("FAIL b2b_in_ready: cycle %0d got 0 want 1", c);
                end else begin
                    idx++;
                end
            end
            if (got) begin
                n_vec++;
                if (o !== e) begin
                    n_err++; $display("FAIL b2b_sb: out %0d got %h want %h", outs, o, e);
                end
                outs++;
                if (first < 0) first = c;
                last = c;
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (outs != 16 || last - first != 15) begin
            n_err++; $display("FAIL b2b_count: got %0d outs over %0d cycles want 16 over 16",
                              outs, last - first + 1);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] sr[12];
        logic [W-1:0] si[12];
        bit   acc, got, was_valid, stall, prev_stall;
        logic ov;
        res_t e, o, prev_o;
        int   idx, outs;
        for (int k = 0; k < 12; k++) begin
            sr[k] = W'($urandom); si[k] = W'($urandom);
        end
        idx = 0; outs = 0; prev_stall = 0; prev_o = '0;
        for (int c = 0; c < 60 && outs < 12; c++) begin
            stall     = (c >= 4 && c < 9);
            out_ready = !stall;
            in_valid  = (idx < 12);
            if (idx < 12) begin in_re = sr[idx]; in_im = si[idx]; end
            was_valid = in_valid;
            sample(acc, got, ov, e, o);
            if (acc) idx++;
            if (stall && was_valid) begin
                n_vec++;
                if (acc) begin
                    n_err++; $display("FAIL bp_in_ready: cycle %0d got 1 want 0", c);
                end
            end
            if (stall) begin
                n_vec++;
                if (ov !== 1'b1) begin
                    n_err++; $display("FAIL bp_out_valid: cycle %0d got %b want 1", c, ov);
                end
            end
            if (stall && prev_stall) begin
                n_vec++;
                if (o !== prev_o) begin
                    n_err++; $display("FAIL bp_stable: cycle %0d got %h want %h", c, o, prev_o);
                end
            end
            if (got) begin
                n_vec++;
                if (o !== e) begin
                    n_err++; $display("FAIL bp_sb: out %0d got %h want %h", outs, o, e);
                end
                outs++;
            end
            prev_stall = stall;
            prev_o     = o;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_vec++;
        if (outs != 12 || exp_q.size() != 0) begin
            n_err++; $display("FAIL bp_count: got %0d outs %0d pending want 12 outs 0 pending",
                              outs, exp_q.size());
        end
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit   acc, got, done;
        logic ov;
        res_t e, o, want;
        int   lat;
        out_ready = 1'b1; in_valid = 1'b1;
        in_re = 12'h0F0; in_im = 12'h00F;
        sample(acc, got, ov, e, o);
        in_re = 12'hF00; in_im = 12'h0FF;
        sample(acc, got, ov, e, o);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_re !== '0) begin
            n_err++; $display("FAIL rstmid_async: got v=%b re=%h want v=0 re=0", out_valid, out_re);
        end
        exp_q.delete();
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL rstmid_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        in_re = 12'h02A; in_im = 12'hFC0; in_valid = 1'b1;
        want = {12'd64, 12'd42, 2'd3, 1'b1};
        sample(acc, got, ov, e, o);
        in_valid = 1'b0;
        lat = 0; done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            sample(acc, got, ov, e, o);
            lat++;
            if (ov) begin
                done = 1;
                n_vec++;
                if (o !== want || lat != 2) begin
                    n_err++; $display("FAIL rstmid_first: got %h lat %0d want %h lat 2", o, lat, want);
                end
            end
        end
        if (!done) begin
            n_vec++; n_err++; $display("FAIL rstmid_timeout: got no output want one");
        end
    endtask

    task automatic test_depths();
        logic [W-1:0] sr[16];
        logic [W-1:0] si[16];
        res_t qa[$];
        res_t qb[$];
        res_t ea, eb, oa, ob;
        int   idx, na, nb, fa, fb, la, lb;
        pulse_reset();
        for (int k = 0; k < 16; k++) begin
            sr[k] = W'($urandom); si[k] = W'($urandom);
        end
        sr[0] = 12'h800; si[0] = 12'h000;
        idx = 0; na = 0; nb = 0; fa = -1; fb = -1; la = -1; lb = -1; out_ready = 1'b1;
        for (int c = 0; c < 40 && (na < 16 || nb < 16); c++) begin
            in_valid = (idx < 16);
            if (idx < 16) begin in_re = sr[idx]; in_im = si[idx]; end
            @(negedge clk);
            if (in_valid) begin
                n_vec++;
                if (!(a_in_ready && b_in_ready)) begin
                    n_err++; $display("FAIL depth_in_ready: cycle %0d got %b%b want 11", c, a_in_ready, b_in_ready);
                end
                qa.push_back(model(in_re, in_im));
                qb.push_back(model(in_re, in_im));
                idx++;
            end
            if (a_out_valid) begin
                oa = {a_out_re, a_out_im, a_out_quadrant, a_out_exchanged};
                ea = (qa.size() > 0) ? qa.pop_front() : 'x;
                n_vec++;
                if (oa !== ea) begin
                    n_err++; $display("FAIL depth1_sb: out %0d got %h want %h", na, oa, ea);
                end
                if (fa < 0) fa = c;
                la = c; na++;
            end
            if (b_out_valid) begin
                ob = {b_out_re, b_out_im, b_out_quadrant, b_out_exchanged};
                eb = (qb.size() > 0) ? qb.pop_front() : 'x;
                n_vec++;
                if (ob !== eb) begin
                    n_err++; $display("FAIL depth4_sb: out %0d got %h want %h", nb, ob, eb);
                end
                if (fb < 0) fb = c;
                lb = c; nb++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_vec++;
        if (fa != 1 || na != 16 || la - fa != 15) begin
            n_err++; $display("FAIL depth1_timing: got first %0d count %0d span %0d want 1 16 15", fa, na, la - fa);
        end
        n_vec++;
        if (fb != 4 || nb != 16 || lb - fb != 15) begin
            n_err++; $display("FAIL depth4_timing: got first %0d count %0d span %0d want 4 16 15", fb, nb, lb - fb);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_directed(12'hF9C, 12'h12C, {12'd300, 12'd100, 2'd1, 1'b1}, "dir_swap");
        test_directed(12'h800, 12'h000, {12'd2047, 12'd0, 2'd1, 1'b0}, "dir_sat");
        test_directed(12'h1F4, 12'hE0C, {12'd500, 12'd500, 2'd3, 1'b0}, "dir_tie");
        test_directed(12'hF38, 12'hF9C, {12'd200, 12'd100, 2'd2, 1'b0}, "dir_q2");
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_depths();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
